lsm_sequencer: RTL and testbench

Load/store-multiple sequencer sitting directly upstream of the 16-bit single-port data memory in the MEM stage. Given a base address and an 8-bit register mask, it issues one memory transfer per cycle, one for each selected register R0–R7, to consecutive addresses. It drives the memory's address, write-data and write-enable inputs and the register-file read/write ports. It holds the pipeline stalled until the sequence completes.

---
 rtl/lsm_sequencer.sv | 115 +++++++++++
 tb/tb_lsm_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer in front of the MEM-stage data memory.
// Walks a register mask low-to-high, one memory transfer per cycle.
module lsm_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_mask,
    output logic [2:0]        rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [2:0]        rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              stall,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic [NREG-1:0]   mask_left;
    logic [2:0]        idx;

    // Lowest set bit wins: scan downward so the last hit is the lowest.
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_q[i]) idx = 3'(i);
        end
    end

    assign mask_left = mask_q & ~(NREG'(1) << idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = is_store;
                    addr_d  = base_addr;
                    mask_d  = reg_mask;
                    state_d = (reg_mask != '0) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                mask_d  = mask_left;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (mask_left != '0) ? S_XFER : S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rf_rd_addr     = '0;
        rf_wr_en       = 1'b0;
        rf_wr_addr     = '0;
        rf_wr_data     = '0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write_en   = 1'b0;
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        stall          = start | busy;
        if (state_q == S_XFER) begin
            mem_address = addr_q;
            // A reset in this cycle abandons the transfer before it commits.
            if (op_q) begin
                rf_rd_addr     = idx;
                mem_write_data = rf_rd_data;
                mem_write_en   = ~rst;
            end else begin
                rf_wr_en   = ~rst;
                rf_wr_addr = idx;
                rf_wr_data = mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Bench for lsm_sequencer: queue-based scoreboard against a
// mask-walking reference model with its own memory/register images.
module tb_lsm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [15:0] base_addr;
    logic [7:0]  reg_mask;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic [15:0] mem_address;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic [15:0] mem_data_out;
    logic        busy;
    logic        stall;
    logic        done;

    lsm_sequencer #(.DATA_W(16), .ADDR_W(16), .NREG(8)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .base_addr(base_addr), .reg_mask(reg_mask),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out),
        .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] init_mem(input logic [15:0] a);
        logic [15:0] t;
        t = a * 16'h9E37;
        return t ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] init_rf(input logic [2:0] i);
        return {4{1'b0, i}} ^ 16'h5A5A;
    endfunction

    // Environment memory and register file (written only by the DUT or preload)
    bit [15:0] mem [65536];
    bit        wm  [65536];
    bit [15:0] rfa [8];
    bit        wr  [8];
    logic        pl_m = 1'b0;
    logic        pl_r = 1'b0;
    logic [15:0] pl_a = '0;
    logic [15:0] pl_d = '0;

    assign mem_data_out = wm[mem_address] ? mem[mem_address] : init_mem(mem_address);
    assign rf_rd_data   = wr[rf_rd_addr] ? rfa[rf_rd_addr] : init_rf(rf_rd_addr);

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_address] <= mem_write_data;
            wm[mem_address]  <= 1'b1;
        end
        if (rf_wr_en) begin
            rfa[rf_wr_addr] <= rf_wr_data;
            wr[rf_wr_addr]  <= 1'b1;
        end
        if (pl_m) begin
            mem[pl_a] <= pl_d;
            wm[pl_a]  <= 1'b1;
        end
        if (pl_r) begin
            rfa[pl_a[2:0]] <= pl_d;
            wr[pl_a[2:0]]  <= 1'b1;
        end
    end

    function automatic logic [15:0] env_mem(input logic [15:0] a);
        return wm[a] ? mem[a] : init_mem(a);
    endfunction

    function automatic logic [15:0] env_rf(input logic [2:0] i);
        return wr[i] ? rfa[i] : init_rf(i);
    endfunction

    // Reference model images
    bit [15:0] rmem [65536];
    bit        rwm  [65536];
    bit [15:0] rrf  [8];
    bit        rwr  [8];

    function automatic logic [15:0] ref_mem(input logic [15:0] a);
        return rwm[a] ? rmem[a] : init_mem(a);
    endfunction

    function automatic logic [15:0] ref_rf(input logic [2:0] i);
        return rwr[i] ? rrf[i] : init_rf(i);
    endfunction

    typedef struct {
        bit          st;
        logic [15:0] addr;
        logic [2:0]  idx;
        logic [15:0] data;
        int          cyc;
    } xfer_t;

    xfer_t xq[$];
    int    dq[$];
    int    busy_lo = 1000000;
    int    busy_hi = -1;
    int    we_cnt  = 0;

    // Monitor: samples mid-cycle, pops expectations as the DUT presents them
    always @(negedge clk) begin
        bit    eb;
        xfer_t e;
        eb = (cyc >= busy_lo) && (cyc <= busy_hi);
        chk("busy", busy, eb);
        chk("stall", stall, start | eb);
        if (!eb)
            chk("idle_outputs", {mem_write_en, rf_wr_en, mem_address, mem_write_data,
                                 rf_wr_addr, rf_wr_data, rf_rd_addr}, 64'h0);
        while (xq.size() > 0 && xq[0].cyc < cyc) begin
            chk("xfer_missing", xq[0].cyc, cyc);
            void'(xq.pop_front());
        end
        while (dq.size() > 0 && dq[0] < cyc) begin
            chk("done_missing", dq[0], cyc);
            void'(dq.pop_front());
        end
        if (mem_write_en || rf_wr_en) begin
            we_cnt++;
            if (xq.size() == 0) begin
                chk("xfer_unexpected", {mem_write_en, rf_wr_en}, 0);
            end else begin
                e = xq.pop_front();
                chk("xfer_cycle", cyc, e.cyc);
                chk("xfer_kind", {mem_write_en, rf_wr_en}, e.st ? 2'b10 : 2'b01);
                chk("xfer_addr", mem_address, e.addr);
                chk("xfer_data", e.st ? mem_write_data : rf_wr_data, e.data);
                chk("xfer_reg", e.st ? rf_rd_addr : rf_wr_addr, e.idx);
            end
        end
        if (done) begin
            if (dq.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycle", cyc, dq.pop_front());
        end
    end

    task automatic pl_mem(input logic [15:0] a, input logic [15:0] v);
        pl_m = 1'b1; pl_a = a; pl_d = v;
        rmem[a] = v; rwm[a] = 1'b1;
        @(posedge clk); #1;
        pl_m = 1'b0;
    endtask

    task automatic pl_rf(input logic [2:0] i, input logic [15:0] v);
        pl_r = 1'b1; pl_a = {13'h0, i}; pl_d = v;
        rrf[i] = v; rwr[i] = 1'b1;
        @(posedge clk); #1;
        pl_r = 1'b0;
    endtask

    // Issue one sequence from IDLE; junk: 0 none, 1 random, 2 cycles 1-2.
    // rst_at > 0 asserts reset during that cycle of the sequence.
    task automatic run_seq(input bit st, input logic [15:0] base, input logic [7:0] mask,
                           input int junk, input int rst_at);
        int          n, keep, s, k;
        logic [15:0] a;
        xfer_t       e;
        n    = $countones(mask);
        keep = (rst_at > 0) ? rst_at - 1 : n;
        is_store  = st;
        base_addr = base;
        reg_mask  = mask;
        start     = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        a = base;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                if (k < keep) begin
                    e.st   = st;
                    e.addr = a;
                    e.idx  = 3'(i);
                    e.cyc  = s + k;
                    if (st) begin
                        e.data = ref_rf(3'(i));
                        rmem[a] = e.data; rwm[a] = 1'b1;
                    end else begin
                        e.data = ref_mem(a);
                        rrf[i] = e.data; rwr[i] = 1'b1;
                    end
                    xq.push_back(e);
                end
                a = a + 16'd1;
                k++;
            end
        end
        if (rst_at == 0) dq.push_back(s + n);
        busy_lo = s;
        busy_hi = (rst_at > 0) ? s + rst_at - 1 : s + n;
        for (int r = 1; r <= n + 1; r++) begin
            start     = (junk == 1) ? 1'($urandom % 2) : (junk == 2 && r <= 2);
            is_store  = 1'($urandom);
            base_addr = 16'($urandom);
            reg_mask  = 8'($urandom);
            if (r == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            if (r == rst_at) begin
                rst = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int          w0, diffs, n, ra;
        bit          st;
        logic [15:0] b;
        logic [7:0]  m;

        rst = 1'b1; start = 1'b1; is_store = 1'b1;
        base_addr = 16'h0040; reg_mask = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // LM, base 128, mask 0x05
        pl_mem(16'd128, 16'd13);
        pl_mem(16'd129, 16'd5);
        run_seq(1'b0, 16'd128, 8'h05, 0, 0);
        chk("lm_r0", env_rf(3'd0), 16'd13);
        chk("lm_r2", env_rf(3'd2), 16'd5);

        // SM, base 0, mask 0x81
        pl_rf(3'd0, 16'h1111);
        pl_rf(3'd7, 16'h7777);
        w0 = we_cnt;
        run_seq(1'b1, 16'd0, 8'h81, 0, 0);
        chk("sm_mem0", env_mem(16'd0), 16'h1111);
        chk("sm_mem1", env_mem(16'd1), 16'h7777);
        chk("sm_we_cycles", we_cnt - w0, 2);

        // Empty mask
        w0 = we_cnt;
        run_seq(1'b1, 16'd5, 8'h00, 0, 0);
        chk("empty_we_cycles", we_cnt - w0, 0);

        // Address wrap
        pl_rf(3'd0, 16'hAAAA);
        pl_rf(3'd1, 16'h5555);
        run_seq(1'b1, 16'hFFFF, 8'h03, 0, 0);
        chk("wrap_ffff", env_mem(16'hFFFF), 16'hAAAA);
        chk("wrap_0000", env_mem(16'h0000), 16'h5555);

        // Reset in cycle 4 of a full-mask store
        pl_rf(3'd0, 16'hA0A0);
        pl_rf(3'd1, 16'hB1B1);
        pl_rf(3'd2, 16'hC2C2);
        run_seq(1'b1, 16'd10, 8'hFF, 0, 4);
        chk("rst_mem10", env_mem(16'd10), 16'hA0A0);
        chk("rst_mem11", env_mem(16'd11), 16'hB1B1);
        chk("rst_mem12", env_mem(16'd12), 16'hC2C2);
        chk("rst_mem13", env_mem(16'd13), init_mem(16'd13));

        // Start pulses while busy are dropped; restart in cycle 6
        run_seq(1'b0, 16'h0200, 8'h0F, 2, 0);
        run_seq(1'b1, 16'h0300, 8'h5A, 0, 0);

        for (int t = 0; t < 40; t++) begin
            st = 1'($urandom);
            b  = ($urandom % 4 == 0) ? 16'hFFF8 + 16'($urandom % 8) : 16'($urandom);
            case ($urandom % 6)
                0:       m = 8'h00;
                1:       m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            n  = $countones(m);
            ra = (n > 0 && $urandom % 8 == 0) ? 1 + int'($urandom % n) : 0;
            run_seq(st, b, m, int'($urandom % 2), ra);
            repeat ($urandom % 3) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("xq_drained", xq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        diffs = 0;
        for (int a = 0; a < 65536; a++)
            if (env_mem(16'(a)) !== ref_mem(16'(a))) diffs++;
        chk("mem_image_diffs", diffs, 0);
        diffs = 0;
        for (int i = 0; i < 8; i++)
            if (env_rf(3'(i)) !== ref_rf(3'(i))) diffs++;
        chk("rf_image_diffs", diffs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
